// File: rtl/ans_stream_ctrl.sv
// ans_stream_ctrl: frames host nibble packets into ans core commands and buffers core output in a FIFO
module ans_stream_ctrl #(
  parameter int FIFO_DEPTH   = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] host_in,
  input  logic       host_in_vld,
  output logic       host_in_rdy,
  output logic [3:0] host_out,
  output logic       host_out_vld,
  input  logic       host_out_rdy,
  output logic [1:0] core_cmd,
  output logic [3:0] core_in,
  output logic       core_in_vld,
  input  logic       core_in_rdy,
  input  logic [3:0] core_out,
  input  logic       core_out_vld,
  output logic       core_out_rdy,
  output logic       busy,
  output logic       err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {HDR, LEN_HI, LEN_LO, PAYLOAD, DRAIN, GAP} state_t;
  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d, cmd_q, cmd_d;
  logic [3:0]    len_hi_q, len_hi_d;
  logic [8:0]    rem_q, rem_d;
  logic [3:0]    idle_q, idle_d;
  logic          err_q, err_d, busy_q;
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          in_xfer, push, pop, full;
  assign in_xfer      = state_q == PAYLOAD && host_in_vld && core_in_rdy;
  assign full         = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign core_out_rdy = !full;
  assign push         = core_out_vld && !full;
  assign host_out_vld = cnt_q != '0;
  assign pop          = host_out_vld && host_out_rdy;
  assign host_out     = host_out_vld ? mem_q[rd_q] : 4'd0;
  assign core_cmd     = cmd_q;
  assign busy         = busy_q;
  assign err          = err_q;
  // packet sequencing: header/length parsing, payload pass-through, drain timing
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cmd_d       = cmd_q;
    len_hi_d    = len_hi_q;
    rem_d       = rem_q;
    idle_d      = 4'd0;
    err_d       = err_q;
    host_in_rdy = 1'b0;
    core_in_vld = 1'b0;
    core_in     = 4'd0;
    case (state_q)
      HDR: begin
        host_in_rdy = 1'b1;
        if (host_in_vld) begin
          if (host_in[1:0] != 2'b00) err_d = 1'b1;
          else if (host_in[3:2] == 2'b11) begin
            err_d   = 1'b0;
            op_d    = 2'b11;
            cmd_d   = 2'b11;
            rem_d   = 9'd16;
            state_d = PAYLOAD;
          end else if (host_in[3:2] != 2'b00) begin
            err_d   = 1'b0;
            op_d    = host_in[3:2];
            state_d = LEN_HI;
          end
        end
      end
      LEN_HI: begin
        host_in_rdy = 1'b1;
        if (host_in_vld) begin
          len_hi_d = host_in;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        host_in_rdy = 1'b1;
        if (host_in_vld) begin
          rem_d   = {1'b0, len_hi_q, host_in} + 9'd1;
          cmd_d   = op_q;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        core_in     = host_in;
        core_in_vld = host_in_vld;
        host_in_rdy = core_in_rdy;
        if (in_xfer) begin
          rem_d   = rem_q - 9'd1;
          state_d = rem_q == 9'd1 ? DRAIN : PAYLOAD;
        end
      end
      DRAIN: begin
        idle_d = core_out_vld ? 4'd0 : idle_q + 4'd1;
        if (idle_d == 4'(DRAIN_CYCLES)) begin
          state_d = GAP;
          cmd_d   = 2'b00;
        end
      end
      GAP:     state_d = HDR;
      default: state_d = HDR;
    endcase
  end
  // control registers; busy is taken from the next state so it tracks the registered state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HDR;
      op_q     <= 2'b00;
      cmd_q    <= 2'b00;
      len_hi_q <= 4'd0;
      rem_q    <= 9'd0;
      idle_q   <= 4'd0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cmd_q    <= cmd_d;
      len_hi_q <= len_hi_d;
      rem_q    <= rem_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      busy_q   <= state_d != HDR;
    end
  end
  // FIFO pointers and occupancy; a full FIFO refuses pushes even when popped the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // FIFO storage; contents are invalidated by the occupancy reset, so no reset here
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= core_out;
  end
endmodule

// File: tb/tb_ans_stream_ctrl.sv
// tb_ans_stream_ctrl: directed packets checked every cycle against a packet-level model
module tb_ans_stream_ctrl;
  localparam int FD = 4;
  localparam int DC = 4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] host_in, host_out, core_in, core_out;
  logic       host_in_vld, host_in_rdy, host_out_vld, host_out_rdy;
  logic [1:0] core_cmd;
  logic       core_in_vld, core_in_rdy, core_out_vld, core_out_rdy, busy, err;
  int         total = 0, passed = 0;
  bit         chk_en = 1'b0;
  int         xf, xf_cmd [4];

  ans_stream_ctrl #(.FIFO_DEPTH(FD), .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_in(host_in), .host_in_vld(host_in_vld), .host_in_rdy(host_in_rdy),
    .host_out(host_out), .host_out_vld(host_out_vld), .host_out_rdy(host_out_rdy),
    .core_cmd(core_cmd), .core_in(core_in), .core_in_vld(core_in_vld), .core_in_rdy(core_in_rdy),
    .core_out(core_out), .core_out_vld(core_out_vld), .core_out_rdy(core_out_rdy),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // packet-level model: where we are in the frame, how much is left, and the FIFO as a queue
  bit         in_pkt, gap, m_pay, pu, po;
  int         len_left, pay_left, quiet, lenv;
  logic [1:0] cmd_m, op_m;
  bit         err_m;
  logic [3:0] fq [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt = 0; gap = 0; len_left = 0; pay_left = 0; quiet = 0; lenv = 0;
      cmd_m = 0; op_m = 0; err_m = 0; fq.delete();
    end else begin
      pu = core_out_vld && fq.size() < FD;
      po = fq.size() > 0 && host_out_rdy;
      if (po) void'(fq.pop_front());
      if (pu) fq.push_back(core_out);
      if (!in_pkt) begin
        if (host_in_vld) begin
          if (host_in[1:0] != 0) err_m = 1;
          else if (host_in[3:2] != 0) begin
            err_m = 0; op_m = host_in[3:2]; in_pkt = 1; quiet = 0; lenv = 0;
            if (op_m == 3) begin pay_left = 16; cmd_m = 3; end
            else len_left = 2;
          end
        end
      end else if (gap) begin
        in_pkt = 0; gap = 0;
      end else if (len_left > 0) begin
        if (host_in_vld) begin
          lenv = lenv * 16 + int'(host_in);
          len_left--;
          if (len_left == 0) begin pay_left = lenv + 1; cmd_m = op_m; end
        end
      end else if (pay_left > 0) begin
        if (host_in_vld && core_in_rdy) pay_left--;
      end else begin
        quiet = core_out_vld ? 0 : quiet + 1;
        if (quiet == DC) begin gap = 1; cmd_m = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      m_pay = in_pkt && !gap && len_left == 0 && pay_left > 0;
      chk("host_in_rdy", host_in_rdy, (!in_pkt || len_left > 0) ? 1'b1 : m_pay ? core_in_rdy : 1'b0);
      chk("core_in_vld", core_in_vld, m_pay && host_in_vld);
      chk("core_in", core_in, m_pay ? host_in : 4'd0);
      chk("core_cmd", core_cmd, cmd_m);
      chk("busy", busy, in_pkt);
      chk("err", err, err_m);
      chk("host_out_vld", host_out_vld, fq.size() > 0);
      chk("host_out", host_out, fq.size() > 0 ? fq[0] : 4'd0);
      chk("core_out_rdy", core_out_rdy, fq.size() < FD);
    end
  end

  always @(negedge clk) begin
    if (rst_n && core_in_vld && core_in_rdy) begin
      xf++;
      xf_cmd[core_cmd]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_xf();
    xf = 0;
    for (int i = 0; i < 4; i++) xf_cmd[i] = 0;
  endtask

  task automatic host_send(input logic [3:0] n);
    logic a = 1'b0;
    host_in = n;
    host_in_vld = 1'b1;
    for (int k = 0; k < 100 && !a; k++) begin
      @(negedge clk);
      a = host_in_rdy;
      tick();
    end
    host_in_vld = 1'b0;
    if (!a) begin
      total++;
      $display("FAIL host_send_timeout: nibble %0h not accepted", n);
    end
  endtask

  task automatic core_push(input logic [3:0] n);
    logic a = 1'b0;
    core_out = n;
    core_out_vld = 1'b1;
    for (int k = 0; k < 60 && !a; k++) begin
      @(negedge clk);
      a = core_out_rdy;
      tick();
    end
    if (!a) begin
      total++;
      $display("FAIL core_push_timeout: nibble %0h not accepted", n);
    end
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      done = !busy;
    end
    chk("wait_idle", done, 1'b1);
    tick();
  endtask

  initial begin
    int n, acc;
    logic [3:0] got [$];
    int exp6 [6];
    exp6 = '{9, 8, 7, 6, 5, 4};
    rst_n = 1'b0;
    host_in = 0; host_in_vld = 0; host_out_rdy = 1; core_in_rdy = 1; core_out = 0; core_out_vld = 0;
    clr_xf();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", core_cmd, 0);
    chk("rst_err", err, 0);
    chk("rst_host_out_vld", host_out_vld, 0);
    chk("rst_host_out", host_out, 0);
    chk("rst_core_out_rdy", core_out_rdy, 1);
    chk("rst_host_in_rdy", host_in_rdy, 1);
    chk("rst_core_in_vld", core_in_vld, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // load packet: 16 nibbles, then 4 drain cycles and a GAP with cmd 00
    clr_xf();
    host_send(4'hC);
    for (int i = 0; i < 16; i++) host_send(4'(i));
    chk("load_xfers", xf, 16);
    chk("load_xfers_cmd11", xf_cmd[3], 16);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (core_cmd == 2'b00) break;
      n++;
    end
    chk("load_drain_cycles", n, 4);
    chk("load_gap_busy", busy, 1);
    @(negedge clk);
    chk("load_busy_fall", busy, 0);
    tick();

    // enc with LEN=2: 3 nibbles with a core stall, then a 4th is refused
    clr_xf();
    host_send(4'h4); host_send(4'h0); host_send(4'h2);
    host_send(4'hA);
    core_in_rdy = 1'b0; host_in = 4'hB; host_in_vld = 1'b1;
    tick(); tick();
    core_in_rdy = 1'b1;
    host_send(4'hB); host_send(4'hC);
    host_in = 4'hD; host_in_vld = 1'b1; acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      acc += int'(host_in_rdy);
    end
    host_in_vld = 1'b0;
    chk("enc_extra_refused", acc, 0);
    chk("enc_xfers", xf, 3);
    chk("enc_xfers_cmd01", xf_cmd[1], 3);
    tick();

    // NOP, then framing error, then a valid dec header clears it
    host_send(4'h0);
    @(negedge clk);
    chk("nop_busy", busy, 0);
    tick();
    host_send(4'h5);
    @(negedge clk);
    chk("ferr_err", err, 1);
    chk("ferr_busy", busy, 0);
    tick();
    host_send(4'h8); host_send(4'h0); host_send(4'h0);
    @(negedge clk);
    chk("dec_cmd", core_cmd, 2);
    chk("dec_err_clr", err, 0);
    tick();
    host_send(4'h7);
    wait_idle();

    // FIFO back-pressure: 6 nibbles with the host stalled, then released
    host_out_rdy = 1'b0;
    core_push(4'h9); core_push(4'h8); core_push(4'h7); core_push(4'h6);
    core_out = 4'h5; core_out_vld = 1'b1;
    @(negedge clk);
    chk("fifo_full_rdy", core_out_rdy, 0);
    chk("fifo_head", host_out, 4'h9);
    tick();
    host_out_rdy = 1'b1;
    fork
      begin
        core_push(4'h5);
        core_push(4'h4);
        core_out_vld = 1'b0;
      end
      begin
        for (int k = 0; k < 60 && got.size() < 6; k++) begin
          @(negedge clk);
          if (host_out_vld) got.push_back(host_out);
        end
      end
    join
    tick();
    chk("fifo_count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("fifo_order[%0d]", i), got[i], exp6[i]);

    // drain extension: a core output in the 3rd drain cycle restarts the idle count
    host_send(4'h4); host_send(4'h0); host_send(4'h0); host_send(4'h1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (core_cmd == 2'b00) break;
      n++;
      core_out = 4'hA;
      core_out_vld = n == 3;
    end
    core_out_vld = 1'b0;
    chk("drain_ext_cycles", n, 7);
    wait_idle();

    // reset mid-payload with a buffered nibble
    clr_xf();
    host_out_rdy = 1'b0;
    host_send(4'h4);
    core_out = 4'h3; core_out_vld = 1'b1;
    host_send(4'h0);
    core_out_vld = 1'b0;
    host_send(4'h2); host_send(4'h1); host_send(4'h2);
    chk("mid_xfers", xf, 2);
    chk("mid_busy", busy, 1);
    chk("mid_cmd", core_cmd, 1);
    chk("mid_fifo_vld", host_out_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_cmd", core_cmd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fifo_vld", host_out_vld, 0);
    chk("arst_host_out", host_out, 0);
    chk("arst_core_out_rdy", core_out_rdy, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    host_out_rdy = 1'b1;
    host_send(4'h8); host_send(4'h0); host_send(4'h0);
    @(negedge clk);
    chk("post_rst_cmd", core_cmd, 2);
    tick();
    host_send(4'h6);
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
